// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity codes and bit-timing helper for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: line synchroniser, falling-edge detect and 3-tap majority around the bit centre
module uart_bit_sampler #(
  parameter int CW = 4,
  parameter int HALF = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          data_rx,
  input  logic [CW-1:0] cnt,
  output logic          rxs,
  output logic          fall,
  output logic          maj,
  output logic          at_sample
);
  logic s1, s3, m0, m1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, rxs, s3, m0, m1} <= '1;
    else begin
      s1 <= data_rx;
      rxs <= s1;
      s3 <= rxs;
      if (cnt == CW'(HALF - 1)) m0 <= rxs;
      if (cnt == CW'(HALF)) m1 <= rxs;
    end
  assign fall = s3 & ~rxs;
  assign maj = (m0 & m1) | (m0 & rxs) | (m1 & rxs);
  assign at_sample = cnt == CW'(HALF + 1);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with glitch rejection, majority voting and frame/parity errors
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_int,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int CW = $clog2(BIT_CNT);
  localparam int HALF = BIT_CNT / 2;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic rxs, fall, maj, at_sample, ferr_r, perr_r, done, par_exp;
  uart_bit_sampler #(.CW(CW), .HALF(HALF)) u_smp (
    .clk(clk), .rst_n(rst_n), .data_rx(data_rx), .cnt(cnt),
    .rxs(rxs), .fall(fall), .maj(maj), .at_sample(at_sample)
  );
  assign par_exp = (^shreg) ^ (PARITY == PARITY_ODD);
  always_comb begin
    state_nx = state;
    done = 1'b0;
    busy = state != S_IDLE;
    case (state)
      S_IDLE:   if (fall) state_nx = S_START;
      S_START:  if (at_sample) state_nx = maj ? S_IDLE : S_DATA;
      S_DATA:   if (at_sample && bit_idx == 4'(DATA_BITS - 1)) state_nx = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
      S_PARITY: if (at_sample) state_nx = S_STOP;
      S_STOP:   if (at_sample && bit_idx == 4'(STOP_BITS - 1)) begin
        done = 1'b1;
        state_nx = ((ferr_r | ~maj) & ~rxs) ? S_BREAK : S_IDLE;
      end
      S_BREAK:  if (rxs) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
      rx_data <= '0;
      rx_int <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      cnt <= (state == S_IDLE || state == S_BREAK || cnt == CW'(BIT_CNT - 1)) ? '0 : cnt + CW'(1);
      bit_idx <= state_nx != state ? '0 : bit_idx + 4'(at_sample);
      if (state == S_START) begin
        ferr_r <= 1'b0;
        perr_r <= 1'b0;
      end
      if (at_sample && state == S_DATA) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (at_sample && state == S_PARITY) perr_r <= maj != par_exp;
      if (at_sample && state == S_STOP && !maj) ferr_r <= 1'b1;
      rx_int <= done;
      if (done) begin
        rx_data <= shreg;
        frame_err <= ferr_r | ~maj;
        parity_err <= perr_r;
      end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param (8N1, 8E1 and 7N2 instances)
module tb_uart_rx_param;
  logic clk = 1'b0, rst_n = 1'b0, line = 1'b1;
  int sel = 0, cyc = 0, t0 = 0, passed = 0, total = 0;
  logic rx_a, rx_p, rx_s;
  logic [7:0] data_a, data_p;
  logic [6:0] data_s;
  logic int_a, fe_a, pe_a, busy_a, int_p, fe_p, pe_p, busy_p, int_s, fe_s, pe_s, busy_s;
  int n_a = 0, n_p = 0, n_s = 0;
  logic [7:0] last_a = '0, last_p = '0;
  logic [6:0] last_s = '0;
  logic lfe_a = 1'b0, lpe_a = 1'b0, lpe_p = 1'b0, lfe_s = 1'b0;
  assign rx_a = sel == 0 ? line : 1'b1;
  assign rx_p = sel == 1 ? line : 1'b1;
  assign rx_s = sel == 2 ? line : 1'b1;
  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_rx(rx_a), .rx_data(data_a), .rx_int(int_a),
    .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
  );
  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .data_rx(rx_p), .rx_data(data_p), .rx_int(int_p),
    .frame_err(fe_p), .parity_err(pe_p), .busy(busy_p)
  );
  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .data_rx(rx_s), .rx_data(data_s), .rx_int(int_s),
    .frame_err(fe_s), .parity_err(pe_s), .busy(busy_s)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (int_a) begin n_a++; last_a = data_a; lfe_a = fe_a; lpe_a = pe_a; end
    if (int_p) begin n_p++; last_p = data_p; lpe_p = pe_p; end
    if (int_s) begin n_s++; last_s = data_s; lfe_s = fe_s; end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end
  task automatic bitw(input logic b);
    line = b;
    repeat (10) @(negedge clk);
  endtask
  task automatic send(input int s, input logic [7:0] d, input int nb, input int par, input int ns, input logic stop_v);
    sel = s;
    t0 = cyc;
    bitw(1'b0);
    for (int i = 0; i < nb; i++) bitw(d[i]);
    if (par >= 0) bitw(par[0]);
    for (int i = 0; i < ns; i++) bitw(stop_v);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (data_a !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", data_a); else passed++;
    total++; if (int_a !== 1'b0) $display("FAIL reset_rx_int: got %b want 0", int_a); else passed++;
    total++; if (fe_a !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", fe_a); else passed++;
    total++; if (pe_a !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", pe_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_8n1;
    int n0, lat;
    logic drop;
    n0 = n_a;
    lat = -1;
    drop = 1'b0;
    fork
      send(0, 8'hA5, 8, -1, 1, 1'b1);
      begin
        repeat (4) @(negedge clk);
        repeat (95) begin
          if (!busy_a) drop = 1'b1;
          @(negedge clk);
        end
      end
    join
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (int_a) lat = cyc - t0;
      else @(negedge clk);
    end
    @(negedge clk);
    total++; if (lat < 96 || lat > 102) $display("FAIL 8n1_latency: got %0d want 96..102", lat); else passed++;
    total++; if (int_a !== 1'b0) $display("FAIL 8n1_strobe_width: got %b want 0 one cycle later", int_a); else passed++;
    total++; if (n_a != n0 + 1) $display("FAIL 8n1_count: got %0d want %0d", n_a, n0 + 1); else passed++;
    total++; if (last_a !== 8'hA5) $display("FAIL 8n1_data: got %h want a5", last_a); else passed++;
    total++; if (lfe_a !== 1'b0 || lpe_a !== 1'b0) $display("FAIL 8n1_errors: got fe=%b pe=%b want 0 0", lfe_a, lpe_a); else passed++;
    total++; if (drop !== 1'b0) $display("FAIL 8n1_busy: got drop=%b want 0", drop); else passed++;
    repeat (20) @(negedge clk);
  endtask
  task automatic test_parity;
    int n0;
    n0 = n_p;
    send(1, 8'h07, 8, 1, 1, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (n_p != n0 + 1) $display("FAIL par_ok_count: got %0d want %0d", n_p, n0 + 1); else passed++;
    total++; if (last_p !== 8'h07) $display("FAIL par_ok_data: got %h want 07", last_p); else passed++;
    total++; if (lpe_p !== 1'b0) $display("FAIL par_ok_err: got %b want 0", lpe_p); else passed++;
    send(1, 8'h07, 8, 0, 1, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (last_p !== 8'h07) $display("FAIL par_bad_data: got %h want 07", last_p); else passed++;
    total++; if (lpe_p !== 1'b1) $display("FAIL par_bad_err: got %b want 1", lpe_p); else passed++;
  endtask
  task automatic test_glitch;
    int n0;
    n0 = n_a;
    sel = 0;
    line = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy_a !== 1'b1) $display("FAIL glitch_busy_rise: got %b want 1", busy_a); else passed++;
    line = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (busy_a !== 1'b0) $display("FAIL glitch_busy_drop: got %b want 0", busy_a); else passed++;
    repeat (120) @(negedge clk);
    total++; if (n_a != n0) $display("FAIL glitch_no_strobe: got %0d strobes want %0d", n_a, n0); else passed++;
  endtask
  task automatic test_break;
    int n0;
    n0 = n_a;
    send(0, 8'h81, 8, -1, 1, 1'b0);
    repeat (30) @(negedge clk);
    total++; if (n_a != n0 + 1) $display("FAIL break_count: got %0d want %0d", n_a, n0 + 1); else passed++;
    total++; if (lfe_a !== 1'b1) $display("FAIL break_frame_err: got %b want 1", lfe_a); else passed++;
    total++; if (last_a !== 8'h81) $display("FAIL break_data: got %h want 81", last_a); else passed++;
    total++; if (busy_a !== 1'b1) $display("FAIL break_busy: got %b want 1", busy_a); else passed++;
    line = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (busy_a !== 1'b0) $display("FAIL break_release: got %b want 0", busy_a); else passed++;
    send(0, 8'h3C, 8, -1, 1, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (n_a != n0 + 2) $display("FAIL break_next_count: got %0d want %0d", n_a, n0 + 2); else passed++;
    total++; if (last_a !== 8'h3C || lfe_a !== 1'b0) $display("FAIL break_next_frame: got %h fe=%b want 3c fe=0", last_a, lfe_a); else passed++;
  endtask
  task automatic test_back_to_back;
    int n0;
    n0 = n_a;
    fork
      begin
        send(0, 8'h55, 8, -1, 1, 1'b1);
        send(0, 8'hAA, 8, -1, 1, 1'b1);
      end
      begin
        repeat (103) @(negedge clk);
        total++; if (n_a != n0 + 1 || last_a !== 8'h55) $display("FAIL b2b_first: got n=%0d data=%h want n=%0d data=55", n_a, last_a, n0 + 1); else passed++;
      end
    join
    repeat (20) @(negedge clk);
    total++; if (n_a != n0 + 2) $display("FAIL b2b_count: got %0d want %0d", n_a, n0 + 2); else passed++;
    total++; if (last_a !== 8'hAA) $display("FAIL b2b_second: got %h want aa", last_a); else passed++;
  endtask
  task automatic test_7n2;
    int n0;
    n0 = n_s;
    send(2, 8'h41, 7, -1, 2, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (n_s != n0 + 1) $display("FAIL 7n2_count: got %0d want %0d", n_s, n0 + 1); else passed++;
    total++; if (last_s !== 7'h41) $display("FAIL 7n2_data: got %h want 41", last_s); else passed++;
    total++; if (lfe_s !== 1'b0) $display("FAIL 7n2_frame_err: got %b want 0", lfe_s); else passed++;
  endtask
  task automatic test_reset_mid;
    int n0;
    logic [7:0] d;
    n0 = n_a;
    d = 8'h96;
    sel = 0;
    bitw(1'b0);
    for (int i = 0; i < 4; i++) bitw(d[i]);
    line = d[4];
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    line = 1'b1;
    #1;
    total++; if (data_a !== 8'h00) $display("FAIL rstmid_data: got %h want 00", data_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_a); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    total++; if (n_a != n0) $display("FAIL rstmid_no_strobe: got %0d want %0d", n_a, n0); else passed++;
    send(0, 8'h96, 8, -1, 1, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (n_a != n0 + 1) $display("FAIL rstmid_next_count: got %0d want %0d", n_a, n0 + 1); else passed++;
    total++; if (last_a !== 8'h96) $display("FAIL rstmid_next_data: got %h want 96", last_a); else passed++;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_7n2();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver for sensor links (e.g. the infrared bump/pit sensor). Replaces the fixed 9600-baud bit-rate generator and receiver pair with one block.
- Generates its own bit timing from CLK_FREQ/BAUD and supports 5–8 data bits and optional parity.
- Rejects start-bit glitches, majority-votes each bit and reports frame/parity errors.
- Feeds byte decoders such as the sensor flag decoder via a one-cycle valid strobe.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate. BIT_CNT = CLK_FREQ/BAUD (truncated), must be ≥ 8.
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2 stop bits checked.

Ports:
- clk  in  1: system clock. All logic is on the rising edge.
- rst_n  in  1: reset, asynchronous assert, active low.
- data_rx  in  1: asynchronous serial line, idle high.
- rx_data  out  DATA_BITS: received word, LSB first on the line.
- rx_int  out  1: one-cycle strobe; rx_data, frame_err and parity_err are valid in this cycle.
- frame_err  out  1: stop bit sampled low. Qualified by rx_int.
- parity_err  out  1: parity mismatch. Qualified by rx_int. Always 0 when PARITY = 0.
- busy  out  1: high from start detection until return to IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rx_data = 0, rx_int = 0, frame_err = 0, parity_err = 0, busy = 0.
  - Synchroniser flops set to 1, FSM goes to IDLE, all counters = 0.
  - Reset mid-frame abandons the frame; no rx_int is produced.
- Input path:
  - 2-flop synchroniser with output rxs.
  - Edge detector on rxs gives a 2-cycle input latency.
- Baud counter:
  - Counts 0..BIT_CNT-1 and restarts at 0 on entering START.
  - The sample point is a 3-sample majority on rxs at counter values HALF-1, HALF and HALF+1, where HALF = BIT_CNT/2.
  - The bit decision is latched at HALF+1.
- FSM states:
  - IDLE: on a falling edge of rxs → START, busy = 1.
  - START: at the sample point, if majority = 1 (glitch) → IDLE with busy = 0 and no strobe; otherwise → DATA.
  - DATA: shifts the majority bit in LSB-first. After DATA_BITS bits → PARITY if PARITY ≠ 0, else → STOP.
  - PARITY: computes the expected bit (odd: XOR of data inverted; even: XOR of data), compares it with the sample and latches the mismatch → STOP.
  - STOP:
    - Samples STOP_BITS bits; frame_err = 1 if any stop sample is 0.
    - After the last stop sample, the next cycle asserts rx_int for exactly 1 cycle and updates rx_data and the error flags.
    - If frame_err = 1 and rxs = 0 → BREAK; otherwise → IDLE.
  - BREAK: waits for rxs = 1, then → IDLE. No new frames are accepted while in BREAK.
- Timing: rx_int occurs (1 + DATA_BITS + P + STOP_BITS − 0.5) × BIT_CNT + 3 cycles (±1) after the line falls, where P = 1 if parity is enabled.
- Error reporting:
  - Error flags hold their values until the next rx_int.
  - rx_data is updated on error frames too.
- Back-to-back frames: a start edge in the cycle after the STOP decision is detected, because IDLE is re-entered before the next falling edge (stop mid-point to next start edge ≥ 0.5 bit).
- Only the registered rx_int is visible; no overlap between frames.
- Baud counter width is $clog2(BIT_CNT); the bit counter is 4 bits.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - PARITY_NONE/ODD/EVEN constants.
  - Function calc_bit_cnt(CLK_FREQ, BAUD).
- One sub-module, uart_bit_sampler: synchroniser, falling-edge detect and 3-tap majority at a given counter value.

Test Plan (CLK_FREQ = 1_000_000, BAUD = 100_000 → BIT_CNT = 10, unless noted):
- 8N1 frame with byte 0xA5 → single rx_int with rx_data = 0xA5, frame_err = 0, parity_err = 0, about 95 + 3 cycles after the start edge; busy high throughout.
- PARITY = 2, byte 0x07 sent with parity bit 1 → rx_data = 0x07, parity_err = 0. Same byte with parity bit 0 → parity_err = 1.
- 3-cycle low glitch on an idle line → no rx_int, FSM back in IDLE, busy drops by cycle 8 after the glitch.
- Stop bit driven 0, then line held low for 30 cycles → rx_int with frame_err = 1. No further rx_int until the line rises, after which the next 0x3C frame is received correctly.
- Two back-to-back frames 0x55, 0xAA with no idle gap → two rx_int strobes with the correct data.
- Separately: DATA_BITS = 7, STOP_BITS = 2 frame 0x41 → rx_data = 0x41.
- Separately: rst_n asserted mid-data-bit 4 → outputs zero immediately, no strobe; the subsequent frame is received correctly.
